// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional tick outputs are enabled elsewhere with the CLKDIV_TICK_EN macro.
package clkdiv_pkg;

    localparam int W_DEF   = 16;
    localparam int DIV_DEF = 71;
    localparam int NCH_MAX = 16;

    // Width of a channel index; a single channel still gets a 1-bit select.
    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: half-period counter, active/pending ratio, toggled output.
// With CLKDIV_TICK_EN defined, also a one-cycle pulse coincident with each new cout level.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int DEFAULT_DIV = DIV_DEF
) (
    input  logic         cin,
    input  logic         rst,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] ld_div,
    output logic         pend,
    output logic         cout
`ifdef CLKDIV_TICK_EN
    ,
    output logic         tick
`endif
);

    logic [W-1:0] cnt;
    logic [W-1:0] div;
    logic [W-1:0] pend_div;
    logic         tc;

    assign tc = (cnt == div);

    // NOTE: non-blocking assignments so every branch below sees pre-edge register values.
    always_ff @(posedge cin) begin
        if (rst) begin
            cnt      <= '0;
            div      <= W'(DEFAULT_DIV);
            pend_div <= '0;
            pend     <= 1'b0;
            cout     <= 1'b0;
        end else if (en) begin
            if (tc) begin
                // Half-period boundary: the only point where the ratio may change.
                cnt  <= '0;
                cout <= ~cout;
                pend <= 1'b0;
                if (ld)
                    div <= ld_div;
                else if (pend)
                    div <= pend_div;
            end else begin
                cnt <= cnt + 1'b1;
                if (ld) begin
                    pend_div <= ld_div;
                    pend     <= 1'b1;
                end
            end
        end else if (ld) begin
            // Stopped channel: no output edge is at risk, so apply at once.
            div <= ld_div;
            cnt <= '0;
        end
    end

`ifdef CLKDIV_TICK_EN
    always_ff @(posedge cin) begin
        if (rst)
            tick <= 1'b0;
        else
            tick <= en & tc;
    end
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable 50%-duty clock divider with a valid/ready ratio load port.
// Define CLKDIV_TICK_EN to add the per-channel terminal-count tick outputs.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int W           = W_DEF,
    parameter int DEFAULT_DIV = DIV_DEF
) (
    input  logic                 cin,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [chw(NCH)-1:0]  ld_ch,
    input  logic [W-1:0]         ld_div,
    output logic [NCH-1:0]       cout
`ifdef CLKDIV_TICK_EN
    ,
    output logic [NCH-1:0]       tick
`endif
);

    if (NCH < 1 || NCH > NCH_MAX) begin : g_bad_nch
        $error("clkdiv_multi: NCH out of range");
    end

    logic [NCH-1:0] pend;
    logic [NCH-1:0] ch_sel;
    logic [NCH-1:0] ld_stb;
    logic           sel_pend;

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    always_comb begin
        ch_sel   = '0;
        sel_pend = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(ld_ch) == i) begin
                ch_sel[i] = 1'b1;
                sel_pend  = pend[i];
            end
        end
    end

    // Out-of-range channel selects nothing, so it reads as ready and is dropped.
    assign ld_ready = ~rst & ~sel_pend;
    assign ld_stb   = ch_sel & {NCH{ld_valid & ld_ready}};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkdiv_chan #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .cin    (cin),
            .rst    (rst),
            .en     (en[g]),
            .ld     (ld_stb[g]),
            .ld_div (ld_div),
            .pend   (pend[g]),
            .cout   (cout[g])
`ifdef CLKDIV_TICK_EN
            ,
            .tick   (tick[g])
`endif
        );
    end

endmodule
